// File: rtl/l23_frame_arbiter.sv
// l23_frame_arbiter: 2:1 round-robin frame arbiter onto one L23 AXI-stream byte channel.
// Grants change only between frames; over-length frames are cut, flagged bad and drained.
module l23_frame_arbiter #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_W         = 16
) (
  input  logic       L23_clk,
  input  logic       L23_rst_n,
  input  logic [7:0] L23i0_tdata,
  input  logic       L23i0_tlast,
  input  logic       L23i0_tuser,
  input  logic       L23i0_tvalid,
  output logic       L23i0_tready,
  input  logic [7:0] L23i1_tdata,
  input  logic       L23i1_tlast,
  input  logic       L23i1_tuser,
  input  logic       L23i1_tvalid,
  output logic       L23i1_tready,
  output logic [7:0] L23o_tdata,
  output logic       L23o_tlast,
  output logic       L23o_tuser,
  output logic       L23o_tvalid,
  input  logic       L23o_tready,
  output logic [1:0] L23_grant,
  output logic       L23_trunc
);
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;
  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;
  logic               sel, g1, pass, drain, rdy, at_max, force_bad, acc;
  logic               s_tvalid, s_tlast, s_tuser;
  logic [7:0]         s_tdata;
  assign sel       = grant_q[1];
  assign s_tdata   = sel ? L23i1_tdata  : L23i0_tdata;
  assign s_tvalid  = sel ? L23i1_tvalid : L23i0_tvalid;
  assign s_tlast   = sel ? L23i1_tlast  : L23i0_tlast;
  assign s_tuser   = sel ? L23i1_tuser  : L23i0_tuser;
  assign pass      = state_q == PASS;
  assign drain     = state_q == DRAIN;
  assign at_max    = cnt_q == CNT_W'(MAX_FRAME_LEN - 1);
  // The MAX-th beat becomes the frame end unless the source already ends there.
  assign force_bad = pass & at_max & ~s_tlast;
  assign L23o_tvalid = pass & s_tvalid;
  assign L23o_tdata  = pass ? s_tdata : 8'h00;
  assign L23o_tlast  = pass & (s_tlast | force_bad);
  assign L23o_tuser  = pass & (s_tuser | force_bad);
  assign rdy          = pass ? L23o_tready : drain;
  assign L23i0_tready = rdy & grant_q[0];
  assign L23i1_tready = rdy & grant_q[1];
  assign acc          = L23o_tvalid & L23o_tready;
  // Source 1 wins when alone, or when both request and source 0 went last.
  assign g1        = L23i1_tvalid & (~L23i0_tvalid | ~last_q);
  assign L23_grant = grant_q;
  assign L23_trunc = trunc_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: if (L23i0_tvalid | L23i1_tvalid) begin
        state_d = PASS;
        grant_d = {g1, ~g1};
        last_d  = g1;
        cnt_d   = '0;
      end
      PASS: if (acc) begin
        cnt_d = cnt_q + 1'b1;
        if (s_tlast) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else if (at_max) begin
          state_d = DRAIN;
          cnt_d   = '0;
          trunc_d = 1'b1;
        end
      end
      DRAIN: if (s_tvalid & s_tlast) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge L23_clk or negedge L23_rst_n) begin
    if (!L23_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
endmodule

// File: tb/tb_l23_frame_arbiter.sv
// tb_l23_frame_arbiter: directed table vectors plus hand sequences for the arbiter.
module tb_l23_frame_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1, od;
  logic       l0, u0, v0, r0, l1, u1, v1, r1, ol, ou, ov, ordy, trunc;
  logic [1:0] grant;
  int         n_cmp = 0, n_bad = 0;

  l23_frame_arbiter #(.MAX_FRAME_LEN(8), .CNT_W(4)) dut (
    .L23_clk(clk), .L23_rst_n(rst_n),
    .L23i0_tdata(d0), .L23i0_tlast(l0), .L23i0_tuser(u0), .L23i0_tvalid(v0), .L23i0_tready(r0),
    .L23i1_tdata(d1), .L23i1_tlast(l1), .L23i1_tuser(u1), .L23i1_tvalid(v1), .L23i1_tready(r1),
    .L23o_tdata(od), .L23o_tlast(ol), .L23o_tuser(ou), .L23o_tvalid(ov), .L23o_tready(ordy),
    .L23_grant(grant), .L23_trunc(trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0, l0, u0, v1, l1, u1, ordy;
    logic [7:0] d0, d1;
    logic ev, el, eu, er0, er1, et;
    logic [7:0] ed;
    logic [1:0] eg;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic iv0, input logic [7:0] id0, input logic il0, input logic iu0,
                              input logic iv1, input logic [7:0] id1, input logic il1, input logic iu1,
                              input logic irdy, input logic ev, input logic [7:0] ed, input logic el,
                              input logic eu, input logic er0, input logic er1, input logic [1:0] eg,
                              input logic et);
    vec_t t;
    t.v0 = iv0; t.d0 = id0; t.l0 = il0; t.u0 = iu0;
    t.v1 = iv1; t.d1 = id1; t.l1 = il1; t.u1 = iu1; t.ordy = irdy;
    t.ev = ev; t.ed = ed; t.el = el; t.eu = eu; t.er0 = er0; t.er1 = er1; t.eg = eg; t.et = et;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    v0 = 0; d0 = 0; l0 = 0; u0 = 0; v1 = 0; d1 = 0; l1 = 0; u1 = 0; ordy = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    v0 = 1; v1 = 1; ordy = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst tvalid", 8'(ov), 8'h0);
    chk("rst tdata", od, 8'h0);
    chk("rst rdy0", 8'(r0), 8'h0);
    chk("rst rdy1", 8'(r1), 8'h0);
    chk("rst grant", 8'(grant), 8'h0);
    chk("rst trunc", 8'(trunc), 8'h0);
    drive_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] t1 [4];
    int beat [2];
    int fr [2];
    int rx, tx, k, src;
    t1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    // Source 0, 4-beat frame
    add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++)
      add(1, t1[i], i == 3, 0, 0, 0, 0, 0, 1, 1, t1[i], i == 3, 0, 1, 0, 2'b01, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // Source 1, 12-beat frame truncated at 8, remainder drained with output stalled
    add(0, 0, 0, 0, 1, 8'h01, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int b = 1; b <= 12; b++)
      if (b <= 8) add(0, 0, 0, 0, 1, 8'(b), 0, 0, 1, 1, 8'(b), b == 8, b == 8, 0, 1, 2'b10, 0);
      else        add(0, 0, 0, 0, 1, 8'(b), b == 12, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, b == 9);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // Source 0, legal 8-beat frame ending exactly at the limit
    add(1, 8'h11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int b = 1; b <= 8; b++)
      add(1, 8'(8'h10 + b), b == 8, 0, 0, 0, 0, 0, 1, 1, 8'(8'h10 + b), b == 8, 0, 1, 0, 2'b01, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    drive_idle();
    rst_n = 1'b0;
    reset_dut();
    foreach (vecs[i]) begin
      @(negedge clk);
      v0 = vecs[i].v0; d0 = vecs[i].d0; l0 = vecs[i].l0; u0 = vecs[i].u0;
      v1 = vecs[i].v1; d1 = vecs[i].d1; l1 = vecs[i].l1; u1 = vecs[i].u1; ordy = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d tvalid", i), 8'(ov), 8'(vecs[i].ev));
      chk($sformatf("row%0d tdata", i), od, vecs[i].ed);
      chk($sformatf("row%0d tlast", i), 8'(ol), 8'(vecs[i].el));
      chk($sformatf("row%0d tuser", i), 8'(ou), 8'(vecs[i].eu));
      chk($sformatf("row%0d rdy0", i), 8'(r0), 8'(vecs[i].er0));
      chk($sformatf("row%0d rdy1", i), 8'(r1), 8'(vecs[i].er1));
      chk($sformatf("row%0d grant", i), 8'(grant), 8'(vecs[i].eg));
      chk($sformatf("row%0d trunc", i), 8'(trunc), 8'(vecs[i].et));
    end

    // Round robin: both sources always valid with 3-beat frames
    reset_dut();
    beat = '{0, 0};
    fr = '{0, 0};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      v0 = 1; v1 = 1; ordy = 1;
      d0 = {1'b0, 3'(fr[0]), 4'(beat[0])}; l0 = beat[0] == 2;
      d1 = {1'b1, 3'(fr[1]), 4'(beat[1])}; l1 = beat[1] == 2;
      #1;
      k = c % 4;
      src = (c / 4) % 2;
      if (k == 0) begin
        chk($sformatf("rr%0d idle tvalid", c), 8'(ov), 8'h0);
        chk($sformatf("rr%0d idle grant", c), 8'(grant), 8'h0);
      end else begin
        chk($sformatf("rr%0d tvalid", c), 8'(ov), 8'h1);
        chk($sformatf("rr%0d grant", c), 8'(grant), src == 1 ? 8'h2 : 8'h1);
        chk($sformatf("rr%0d tdata", c), od, {src[0], 3'(c / 8), 4'(k - 1)});
        chk($sformatf("rr%0d other rdy", c), 8'(src == 1 ? r0 : r1), 8'h0);
      end
      if (v0 & r0) begin if (beat[0] == 2) begin beat[0] = 0; fr[0]++; end else beat[0]++; end
      if (v1 & r1) begin if (beat[1] == 2) begin beat[1] = 0; fr[1]++; end else beat[1]++; end
    end

    // Random gaps and backpressure on a 6-beat frame, tuser on last beat
    reset_dut();
    rx = 0;
    tx = 0;
    for (int c = 0; c < 300 && rx < 6; c++) begin
      @(negedge clk);
      v0 = (tx < 6) && ($urandom_range(0, 2) != 0);
      d0 = 8'(8'hA0 + tx); l0 = tx == 5; u0 = tx == 5;
      v1 = 0;
      ordy = 1'($urandom_range(0, 1));
      #1;
      if (ov) chk("rnd passthrough", od, 8'(8'hA0 + tx));
      if (ov & ordy) begin
        chk("rnd order", od, 8'(8'hA0 + rx));
        chk("rnd tuser", 8'(ou), 8'(rx == 5));
        chk("rnd tlast", 8'(ol), 8'(rx == 5));
        rx++;
      end
      if (v0 & r0) tx++;
    end
    chk("rnd delivered", 8'(rx), 8'd6);

    // Reset asserted at beat 3, then both request: source 0 must win
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      v0 = 1; d0 = 8'(c); l0 = 0; u0 = 0; v1 = 0; ordy = 1;
    end
    #1;
    chk("mid beat3 tvalid", 8'(ov), 8'h1);
    rst_n = 1'b0;
    v1 = 1;
    #1;
    chk("mid rst tvalid", 8'(ov), 8'h0);
    chk("mid rst rdy0", 8'(r0), 8'h0);
    chk("mid rst rdy1", 8'(r1), 8'h0);
    chk("mid rst grant", 8'(grant), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst grant", 8'(grant), 8'h1);
    chk("post rst tdata", od, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
